uart_tx_arbiter: RTL and testbench

- Shares one UART serial transmit line among NUM_REQ byte producers using round-robin arbitration with optional multi-byte lock.
- Contains the baud divider and the 10-bit frame serialiser. Frame format is 8N1: start bit 0, data LSB first, stop bit 1.
- Is the transmit-side counterpart of the UART receive path; `tx_serial` drives the board TX pin or a loopback into the receiver.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_shifter.sv | 54 +++++
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit arbiter state encoding.
package uart_pkg;

  localparam int unsigned UART_FRAME_BITS = 10;
  localparam logic        UART_IDLE_LEVEL = 1'b1;
  localparam int unsigned DEFAULT_CLK_DIV = 434;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_NEXT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_shifter.sv
// 8N1 frame serialiser: baud divider, 10-bit shift register and bit counter.
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_tx_serial,
  output logic       o_done
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0]           r_div;
  logic [3:0]                 r_bit;
  logic [UART_FRAME_BITS-1:0] r_shift;
  logic                       r_active;
  logic                       w_div_end;

  assign w_div_end   = (r_div == DIV_W'(CLK_DIV - 1));
  assign o_done      = r_active && w_div_end && (r_bit == 4'(UART_FRAME_BITS - 1));
  // Idle level comes straight from the async-reset flop, so reset forces the line high at once.
  assign o_tx_serial = r_active ? r_shift[0] : UART_IDLE_LEVEL;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div    <= '0;
      r_bit    <= '0;
      r_shift  <= {UART_FRAME_BITS{UART_IDLE_LEVEL}};
      r_active <= 1'b0;
    end else if (i_load) begin
      r_div    <= '0;
      r_bit    <= '0;
      r_shift  <= {UART_IDLE_LEVEL, i_data, 1'b0};
      r_active <= 1'b1;
    end else if (r_active) begin
      if (w_div_end) begin
        r_div <= '0;
        if (o_done) begin
          r_active <= 1'b0;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_shift <= {UART_IDLE_LEVEL, r_shift[UART_FRAME_BITS-1:1]};
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX line among NUM_REQ byte producers, with message lock.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CLK_DIV      = DEFAULT_CLK_DIV,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [8*NUM_REQ-1:0]       i_req_data,
  input  logic [NUM_REQ-1:0]         i_req_last,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_tx_serial,
  output logic                       o_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_lock_timeout
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e        r_state, w_state_next;
  logic [GW-1:0]     r_rr_ptr, w_rr_next;
  logic [GW-1:0]     r_grant_id;
  logic              r_last;
  logic [TW-1:0]     r_tmo, w_tmo_next;

  logic [GW-1:0]     w_idx, w_win, w_sel;
  logic              w_found, w_accept, w_done, w_timeout, w_last;
  logic [7:0]        w_data;
  logic [NUM_REQ-1:0] w_ready;

  // First valid requester after rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      w_idx = GW'((int'(r_rr_ptr) + k) % int'(NUM_REQ));
      if (!w_found && i_req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rr_next    = r_rr_ptr;
    w_tmo_next   = r_tmo;
    w_ready      = '0;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    w_sel        = w_win;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_ready[w_win] = 1'b1;
          w_accept       = 1'b1;
          w_state_next   = SEND;
        end
      end
      SEND: begin
        if (w_done) begin
          if (r_last) begin
            w_rr_next    = r_grant_id;
            w_state_next = IDLE;
          end else begin
            w_tmo_next   = '0;
            w_state_next = WAIT_NEXT;
          end
        end
      end
      WAIT_NEXT: begin
        w_sel = r_grant_id;
        if (r_tmo == TW'(LOCK_TIMEOUT)) begin
          // Lock revoked: ready stays low this cycle so the stalled owner cannot slip in.
          w_timeout    = 1'b1;
          w_rr_next    = r_grant_id;
          w_state_next = IDLE;
        end else begin
          w_ready[r_grant_id] = 1'b1;
          if (i_req_valid[r_grant_id]) begin
            w_accept     = 1'b1;
            w_state_next = SEND;
          end else begin
            w_tmo_next = r_tmo + TW'(1);
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_data = '0;
    w_last = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_sel == GW'(i)) begin
        w_data = i_req_data[8*i +: 8];
        w_last = i_req_last[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= GW'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_last     <= 1'b1;
      r_tmo      <= '0;
    end else begin
      r_state  <= w_state_next;
      r_rr_ptr <= w_rr_next;
      r_tmo    <= w_tmo_next;
      if (w_accept) begin
        r_grant_id <= w_sel;
        r_last     <= w_last;
      end
    end
  end

  uart_tx_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_data     (w_data),
    .o_tx_serial(o_tx_serial),
    .o_done     (w_done)
  );

  assign o_req_ready    = w_ready;
  assign o_busy         = (r_state != IDLE);
  assign o_grant_id     = r_grant_id;
  assign o_lock_timeout = w_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_uart_tx_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned DIV = 4;
  localparam int unsigned LTO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  valid;
  logic [31:0] data;
  logic [3:0]  last;
  logic [3:0]  ready;
  logic        tx;
  logic        busy;
  logic [1:0]  gid;
  logic        lto;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    int          grant;
    logic [3:0]  ready;
    logic [7:0]  dbyte;
    logic        busy_after;
  } vec_t;

  vec_t vecs[8];

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .CLK_DIV     (DIV),
    .LOCK_TIMEOUT(LTO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_req_valid   (valid),
    .i_req_data    (data),
    .i_req_last    (last),
    .o_req_ready   (ready),
    .o_tx_serial   (tx),
    .o_busy        (busy),
    .o_grant_id    (gid),
    .o_lock_timeout(lto)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Returns at the negedge just after the accept edge (first start-bit cycle).
  task automatic wait_accept(output int lane, output logic [3:0] rdy, output int waited);
    lane   = -1;
    rdy    = '0;
    waited = 0;
    while (lane < 0 && waited < 200) begin
      #1;
      if ((ready & valid) != 4'b0) begin
        rdy = ready;
        for (int i = 0; i < 4; i++) if (ready[i] && valid[i]) lane = i;
      end else begin
        @(negedge clk);
        waited++;
      end
    end
    check("accept_seen", 32'(lane >= 0), 32'd1);
    if (lane >= 0) @(negedge clk);
  endtask

  // Checks every cycle of one frame; ends at the negedge of the gap cycle after the stop bit.
  task automatic capture(input logic [7:0] b, input string name);
    logic [9:0] fr;
    logic [9:0] got;
    int         bad;
    fr  = {1'b1, b, 1'b0};
    got = '0;
    bad = 0;
    for (int c = 0; c < int'(10 * DIV); c++) begin
      if (tx !== fr[c / int'(DIV)] || busy !== 1'b1 || ready !== 4'b0) bad++;
      if (c % int'(DIV) == 1) got[c / int'(DIV)] = tx;
      @(negedge clk);
    end
    check({name, "_bits"}, 32'(got), 32'(fr));
    check({name, "_cycles"}, 32'(bad), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int         lane;
    int         waited;
    int         n;
    logic [3:0] rdy;

    vecs[0] = '{4'hF, 4'hF, 32'h4433_2211, 0, 4'b0001, 8'h11, 1'b0};
    vecs[1] = '{4'hF, 4'hF, 32'h4433_2211, 1, 4'b0010, 8'h22, 1'b0};
    vecs[2] = '{4'hF, 4'hF, 32'h4433_2211, 2, 4'b0100, 8'h33, 1'b0};
    vecs[3] = '{4'hF, 4'hF, 32'h4433_2211, 3, 4'b1000, 8'h44, 1'b0};
    vecs[4] = '{4'hF, 4'hF, 32'h4433_22C3, 0, 4'b0001, 8'hC3, 1'b0};
    vecs[5] = '{4'b0011, 4'b0001, 32'h0000_1199, 1, 4'b0010, 8'h11, 1'b1};
    vecs[6] = '{4'b0011, 4'b0011, 32'h0000_2299, 1, 4'b0010, 8'h22, 1'b0};
    vecs[7] = '{4'b0001, 4'b0011, 32'h0000_2299, 0, 4'b0001, 8'h99, 1'b0};

    reset = 1'b1;
    valid = '0;
    data  = '0;
    last  = '0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'({tx, busy, gid, lto, ready}), 32'(9'b1_0_00_0_0000));
    reset = 1'b0;

    // Single byte on lane 2.
    valid = 4'b0100;
    data  = 32'h00A5_0000;
    last  = 4'b0100;
    wait_accept(lane, rdy, waited);
    check("t1_lane", 32'(lane), 32'd2);
    check("t1_ready", 32'(rdy), 32'(4'b0100));
    valid = '0;
    capture(8'hA5, "t1_frame");
    #1 check("t1_idle", 32'({tx, busy, gid, ready}), 32'({1'b1, 1'b0, 2'd2, 4'b0000}));

    // Round-robin and locked message from the vector table.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      valid = vecs[i].valid;
      last  = vecs[i].last;
      data  = vecs[i].data;
      wait_accept(lane, rdy, waited);
      check($sformatf("v%0d_lane", i), 32'(lane), 32'(vecs[i].grant));
      check($sformatf("v%0d_ready", i), 32'(rdy), 32'(vecs[i].ready));
      check($sformatf("v%0d_gap", i), 32'(waited), 32'd0);
      check($sformatf("v%0d_gid", i), 32'(gid), 32'(vecs[i].grant));
      capture(vecs[i].dbyte, $sformatf("v%0d_frame", i));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy_after));
    end

    // Lock timeout: lane 1 stalls mid-message, lane 3 waits.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    valid = 4'b1010;
    data  = 32'h7E00_5E00;
    last  = 4'b1000;
    wait_accept(lane, rdy, waited);
    check("t4_lane", 32'(lane), 32'd1);
    capture(8'h5E, "t4_frame");
    check("t4_wait_ready", 32'({busy, ready}), 32'({1'b1, 4'b0010}));
    valid = 4'b1000;
    n = 0;
    while (!lto && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_timeout_delay", 32'(n), 32'(LTO));
    check("t4_pulse_state", 32'({ready, gid}), 32'({4'b0000, 2'd1}));
    valid = 4'b1010;
    last  = 4'b1010;
    @(negedge clk);
    #1 check("t4_after_pulse", 32'({lto, busy}), 32'd0);
    wait_accept(lane, rdy, waited);
    check("t4_next_lane", 32'(lane), 32'd3);
    check("t4_next_ready", 32'(rdy), 32'(4'b1000));
    valid = '0;
    capture(8'h7E, "t4_frame3");

    // Reset in the middle of data bit 3.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    valid = 4'b0100;
    data  = 32'h00F0_0000;
    last  = 4'hF;
    wait_accept(lane, rdy, waited);
    check("t5_lane", 32'(lane), 32'd2);
    valid = '0;
    repeat (17) @(negedge clk);
    check("t5_d3_low", 32'(tx), 32'd0);
    #1 reset = 1'b1;
    #1 check("t5_async", 32'({tx, busy}), 32'({1'b1, 1'b0}));
    valid = 4'b0101;
    data  = 32'h005C_003A;
    @(negedge clk);
    reset = 1'b0;
    wait_accept(lane, rdy, waited);
    check("t5_lane_after", 32'(lane), 32'd0);
    check("t5_ready_after", 32'(rdy), 32'(4'b0001));
    valid = '0;
    capture(8'h3A, "t5_frame");

    // Lane 2 withdraws in the same cycle lane 1 raises valid.
    valid = 4'b0100;
    data  = 32'h00EE_4200;
    last  = 4'hF;
    #1 valid = 4'b0010;
    #1 check("t6_ready", 32'(ready), 32'(4'b0010));
    @(negedge clk);
    check("t6_gid", 32'(gid), 32'd1);
    valid = '0;
    capture(8'h42, "t6_frame");
    #1 check("t6_idle", 32'({tx, busy, ready}), 32'({1'b1, 1'b0, 4'b0000}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
